// File: rtl/parking_pkg.sv
// parking_pkg: shared rush-episode state type and saturating increment helper.
package parking_pkg;

    typedef enum logic [1:0] {IDLE, RUSH, ENDED} rush_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/parking_hour_hist.sv
// parking_hour_hist: per-hour saturating entry counters with combinational read port.
module parking_hour_hist
    import parking_pkg::*;
#(
    parameter int HOUR_W  = 3,
    parameter int TOTAL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic [HOUR_W-1:0]  hour,
    input  logic [HOUR_W-1:0]  hist_sel,
    output logic [TOTAL_W-1:0] hist_count
);

    localparam int NUM_HOURS = 2 ** HOUR_W;
    localparam logic [31:0] LIM = 32'((64'd1 << TOTAL_W) - 64'd1);

    logic [TOTAL_W-1:0] cnt [NUM_HOURS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_HOURS; i++) cnt[i] <= '0;
        end else if (inc) begin
            cnt[hour] <= TOTAL_W'(sat_inc(32'(cnt[hour]), LIM));
        end
    end

    assign hist_count = cnt[hist_sel];

endmodule

// File: rtl/parking_lot_tracker.sv
// parking_lot_tracker: gate arbitration, occupancy, entry totals and rush-episode tracking.
// Optional per-hour entry histogram built when PARKING_HOURLY_HIST_EN is defined.
module parking_lot_tracker
    import parking_pkg::*;
#(
    parameter int CAPACITY   = 3,
    parameter int HOUR_W     = 3,
    parameter int TOTAL_W    = 4,
    parameter int MULTI_RUSH = 0,
    parameter int RCNT_W     = 3,
    localparam int OCC_W     = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               entry_req,
    input  logic               exit_req,
    input  logic [HOUR_W-1:0]  hour,
    output logic [OCC_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic               entry_ack,
    output logic               exit_ack,
    output logic [TOTAL_W-1:0] total_entries,
    output logic               total_sat,
    output logic               rush_active,
    output logic               rush_done,
    output logic [HOUR_W-1:0]  rush_start_hour,
    output logic [HOUR_W-1:0]  rush_end_hour,
    output logic [RCNT_W-1:0]  rush_count,
    input  logic [HOUR_W-1:0]  hist_sel,
    output logic [TOTAL_W-1:0] hist_count
);

    localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);
    localparam logic [31:0] TOT_LIM  = 32'((64'd1 << TOTAL_W) - 64'd1);
    localparam logic [31:0] RCNT_LIM = 32'((64'd1 << RCNT_W) - 64'd1);

    rush_state_t      state, state_next;
    logic [OCC_W-1:0] occ_next;
    logic             start_cap, end_cap;

    assign full      = occupancy == CAP;
    assign empty     = occupancy == '0;
    assign exit_ack  = exit_req & !empty;
    // A departing car frees its space in the same cycle, so a full lot still admits a paired entry.
    assign entry_ack = entry_req & (!full | exit_ack);
    assign total_sat = &total_entries;
    assign rush_active = state == RUSH;
    assign rush_done   = state == ENDED;

    always_comb begin
        occ_next   = (entry_ack & !exit_ack) ? occupancy + OCC_W'(1) :
                     (exit_ack & !entry_ack) ? occupancy - OCC_W'(1) : occupancy;
        start_cap  = occ_next == CAP && (state == IDLE || (MULTI_RUSH != 0 && state == ENDED));
        end_cap    = state == RUSH && occ_next == '0;
        state_next = start_cap ? RUSH : end_cap ? ENDED : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            occupancy       <= '0;
            total_entries   <= '0;
            rush_start_hour <= '0;
            rush_end_hour   <= '0;
            rush_count      <= '0;
        end else begin
            state     <= state_next;
            occupancy <= occ_next;
            if (entry_ack) total_entries <= TOTAL_W'(sat_inc(32'(total_entries), TOT_LIM));
            if (start_cap) begin
                rush_start_hour <= hour;
                rush_count      <= RCNT_W'(sat_inc(32'(rush_count), RCNT_LIM));
            end
            if (end_cap) rush_end_hour <= hour;
        end
    end

`ifdef PARKING_HOURLY_HIST_EN
    parking_hour_hist #(
        .HOUR_W (HOUR_W),
        .TOTAL_W(TOTAL_W)
    ) u_hist (
        .clk       (clk),
        .reset     (reset),
        .inc       (entry_ack),
        .hour      (hour),
        .hist_sel  (hist_sel),
        .hist_count(hist_count)
    );
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_parking_lot_tracker.sv
// tb_parking_lot_tracker: directed vectors with a scoreboard queue checked by a decoupled monitor.
module tb_parking_lot_tracker;

`ifdef PARKING_HOURLY_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    typedef struct {
        int idx;
        int en, ex, hr, sel;
        int eack, xack, occ, full, empty, tot, tsat;
        int ract, rdone, rst, rend, rcnt, hist, m1a, m1c;
    } vec_t;

    logic       clk, reset, entry_req, exit_req;
    logic [2:0] hour, hist_sel;
    logic [1:0] occupancy, m1_occupancy;
    logic       full, empty, entry_ack, exit_ack, total_sat, rush_active, rush_done;
    logic       m1_full, m1_empty, m1_entry_ack, m1_exit_ack, m1_total_sat, m1_rush_active, m1_rush_done;
    logic [3:0] total_entries, hist_count, m1_total_entries, m1_hist_count;
    logic [2:0] rush_start_hour, rush_end_hour, rush_count;
    logic [2:0] m1_rush_start_hour, m1_rush_end_hour, m1_rush_count;

    vec_t vecs[$];
    vec_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    parking_lot_tracker dut (
        .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req), .hour(hour),
        .occupancy(occupancy), .full(full), .empty(empty), .entry_ack(entry_ack), .exit_ack(exit_ack),
        .total_entries(total_entries), .total_sat(total_sat), .rush_active(rush_active),
        .rush_done(rush_done), .rush_start_hour(rush_start_hour), .rush_end_hour(rush_end_hour),
        .rush_count(rush_count), .hist_sel(hist_sel), .hist_count(hist_count)
    );

    parking_lot_tracker #(.MULTI_RUSH(1)) dut_m1 (
        .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req), .hour(hour),
        .occupancy(m1_occupancy), .full(m1_full), .empty(m1_empty), .entry_ack(m1_entry_ack),
        .exit_ack(m1_exit_ack), .total_entries(m1_total_entries), .total_sat(m1_total_sat),
        .rush_active(m1_rush_active), .rush_done(m1_rush_done), .rush_start_hour(m1_rush_start_hour),
        .rush_end_hour(m1_rush_end_hour), .rush_count(m1_rush_count), .hist_sel(hist_sel),
        .hist_count(m1_hist_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int en, ex, hr, sel, eack, xack, occ, full_e, empty_e, tot, tsat,
                       ract, rdone, rst, rend, rcnt, hist, m1a, m1c);
        vec_t v;
        v.idx = vecs.size();
        v.en = en; v.ex = ex; v.hr = hr; v.sel = sel;
        v.eack = eack; v.xack = xack; v.occ = occ; v.full = full_e; v.empty = empty_e;
        v.tot = tot; v.tsat = tsat; v.ract = ract; v.rdone = rdone; v.rst = rst; v.rend = rend;
        v.rcnt = rcnt; v.hist = hist; v.m1a = m1a; v.m1c = m1c;
        vecs.push_back(v);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " occ"}, 32'(occupancy), 0);
        chk({tag, " empty"}, 32'(empty), 1);
        chk({tag, " full"}, 32'(full), 0);
        chk({tag, " total"}, 32'(total_entries), 0);
        chk({tag, " tsat"}, 32'(total_sat), 0);
        chk({tag, " ract"}, 32'(rush_active), 0);
        chk({tag, " rdone"}, 32'(rush_done), 0);
        chk({tag, " rstart"}, 32'(rush_start_hour), 0);
        chk({tag, " rend"}, 32'(rush_end_hour), 0);
        chk({tag, " rcnt"}, 32'(rush_count), 0);
        chk({tag, " hist"}, 32'(hist_count), 0);
        chk({tag, " m1 rcnt"}, 32'(m1_rush_count), 0);
        chk({tag, " m1 ract"}, 32'(m1_rush_active), 0);
    endtask

    // Monitor: acks sampled mid-low phase, registered state just after the edge.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q[0];
                chk($sformatf("v%0d eack", e.idx), 32'(entry_ack), e.eack);
                chk($sformatf("v%0d xack", e.idx), 32'(exit_ack), e.xack);
                @(posedge clk);
                #1;
                chk($sformatf("v%0d occ", e.idx), 32'(occupancy), e.occ);
                chk($sformatf("v%0d full", e.idx), 32'(full), e.full);
                chk($sformatf("v%0d empty", e.idx), 32'(empty), e.empty);
                chk($sformatf("v%0d total", e.idx), 32'(total_entries), e.tot);
                chk($sformatf("v%0d tsat", e.idx), 32'(total_sat), e.tsat);
                chk($sformatf("v%0d ract", e.idx), 32'(rush_active), e.ract);
                chk($sformatf("v%0d rdone", e.idx), 32'(rush_done), e.rdone);
                chk($sformatf("v%0d rstart", e.idx), 32'(rush_start_hour), e.rst);
                chk($sformatf("v%0d rend", e.idx), 32'(rush_end_hour), e.rend);
                chk($sformatf("v%0d rcnt", e.idx), 32'(rush_count), e.rcnt);
                chk($sformatf("v%0d hist", e.idx), 32'(hist_count), HIST ? e.hist : 0);
                chk($sformatf("v%0d m1 ract", e.idx), 32'(m1_rush_active), e.m1a);
                chk($sformatf("v%0d m1 rcnt", e.idx), 32'(m1_rush_count), e.m1c);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        //   en ex hr sel eack xack occ full empty tot tsat ract rdone rst rend rcnt hist m1a m1c
        add(1, 0, 1, 1,  1, 0, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0,  1,  0, 0);
        add(1, 0, 1, 1,  1, 0, 2, 0, 0,  2, 0,  0, 0, 0, 0, 0,  2,  0, 0);
        add(1, 0, 2, 1,  1, 0, 3, 1, 0,  3, 0,  1, 0, 2, 0, 1,  2,  1, 1);
        add(1, 0, 2, 2,  0, 0, 3, 1, 0,  3, 0,  1, 0, 2, 0, 1,  1,  1, 1);
        add(1, 1, 3, 2,  1, 1, 3, 1, 0,  4, 0,  1, 0, 2, 0, 1,  1,  1, 1);
        add(0, 1, 4, 3,  0, 1, 2, 0, 0,  4, 0,  1, 0, 2, 0, 1,  1,  1, 1);
        add(0, 1, 5, 3,  0, 1, 1, 0, 0,  4, 0,  1, 0, 2, 0, 1,  1,  1, 1);
        add(0, 1, 5, 3,  0, 1, 0, 0, 1,  4, 0,  0, 1, 2, 5, 1,  1,  0, 1);
        add(0, 1, 5, 3,  0, 0, 0, 0, 1,  4, 0,  0, 1, 2, 5, 1,  1,  0, 1);
        add(1, 1, 6, 6,  1, 0, 1, 0, 0,  5, 0,  0, 1, 2, 5, 1,  1,  0, 1);
        add(1, 0, 6, 6,  1, 0, 2, 0, 0,  6, 0,  0, 1, 2, 5, 1,  2,  0, 1);
        add(1, 0, 7, 6,  1, 0, 3, 1, 0,  7, 0,  0, 1, 2, 5, 1,  2,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0,  8, 0,  0, 1, 2, 5, 1,  1,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0,  9, 0,  0, 1, 2, 5, 1,  2,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0, 10, 0,  0, 1, 2, 5, 1,  3,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0, 11, 0,  0, 1, 2, 5, 1,  4,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0, 12, 0,  0, 1, 2, 5, 1,  5,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0, 13, 0,  0, 1, 2, 5, 1,  6,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0, 14, 0,  0, 1, 2, 5, 1,  7,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0, 15, 1,  0, 1, 2, 5, 1,  8,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0, 15, 1,  0, 1, 2, 5, 1,  9,  1, 2);
        add(1, 1, 0, 0,  1, 1, 3, 1, 0, 15, 1,  0, 1, 2, 5, 1, 10,  1, 2);
        add(0, 1, 4, 4,  0, 1, 2, 0, 0, 15, 1,  0, 1, 2, 5, 1,  0,  1, 2);
        add(1, 0, 4, 4,  1, 0, 3, 1, 0, 15, 1,  0, 1, 2, 5, 1,  1,  1, 2);
        add(0, 1, 4, 4,  0, 1, 2, 0, 0, 15, 1,  0, 1, 2, 5, 1,  1,  1, 2);
        add(1, 1, 4, 4,  1, 1, 2, 0, 0, 15, 1,  0, 1, 2, 5, 1,  2,  1, 2);
        add(1, 0, 4, 4,  1, 0, 3, 1, 0, 15, 1,  0, 1, 2, 5, 1,  3,  1, 2);
        add(0, 0, 4, 1,  0, 0, 3, 1, 0, 15, 1,  0, 1, 2, 5, 1,  2,  1, 2);
        add(0, 1, 2, 2,  0, 1, 2, 0, 0, 15, 1,  0, 1, 2, 5, 1,  1,  1, 2);
        add(0, 1, 2, 2,  0, 1, 1, 0, 0, 15, 1,  0, 1, 2, 5, 1,  1,  1, 2);
        add(0, 1, 2, 7,  0, 1, 0, 0, 1, 15, 1,  0, 1, 2, 5, 1,  1,  0, 2);
        add(1, 0, 3, 3,  1, 0, 1, 0, 0, 15, 1,  0, 1, 2, 5, 1,  2,  0, 2);
        // after the mid-low asynchronous reset
        add(1, 0, 4, 4,  1, 0, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0,  1,  0, 0);

        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; hour = '0; hist_sel = '0;
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 32) begin
                @(negedge clk);
                #2 reset = 1'b1;
                entry_req = 1'b0;
                exit_req = 1'b0;
                #1 chk_zero("async reset");
                #1 reset = 1'b0;
            end
            @(negedge clk);
            entry_req = vecs[i].en[0];
            exit_req  = vecs[i].ex[0];
            hour      = 3'(vecs[i].hr);
            hist_sel  = 3'(vecs[i].sel);
            q.push_back(vecs[i]);
        end
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
